rxll_ll: RTL and testbench
==========================

RXLL_LL -- requirements
Module: rxll_ll

Interface
REQ-001 Parameter C_MAX_WORDS, default 512: max words per frame, including the SOF word; range 2..1023.
REQ-002 phyclk  in  1  sole clock; all logic on its rising edge.
REQ-003 phyreset_n  in  1  synchronous, active-low reset.
REQ-004 trn_rd  in  32  LocalLink receive data.
REQ-005 trn_rsof_n / trn_reof_n  in  1 each  start / end of frame, active low.
REQ-006 trn_rsrc_rdy_n  in  1  source valid, active low.
REQ-007 trn_rsrc_dsc_n  in  1  source discontinue, active low.
REQ-008 trn_rdst_rdy_n  out  1  destination ready, active low, registered.
REQ-009 wr_clk  out  1  equals phyclk.
REQ-010 wr_en  out  1  FIFO write strobe, registered.
REQ-011 wr_di  out  36  FIFO word: [35]=sof, [34]=eof, [33]=abort, [32]=0, [31:0]=data.
REQ-012 wr_full / wr_almost_full  in  1 each  FIFO status; almost_full leaves at least 3 free words.
REQ-013 rx_frame_done  out  1  one-cycle pulse when a frame's eof word is written.
REQ-014 rx_frame_len  out  10  word count of the last completed or aborted frame; held until the next done.
REQ-015 rx_frame_abort  out  1  qualifies rx_frame_done: frame was terminated with abort.
REQ-016 rx_err_nosof / rx_err_ovf  out  1 each  one-cycle error pulses.

Function
REQ-017 A beat is accepted when trn_rsrc_rdy_n=0 and trn_rdst_rdy_n=0.
REQ-018 trn_rdst_rdy_n is registered as (wr_almost_full | wr_full).
- Deasserts one cycle after almost_full rises.
REQ-019 Each written word appears on wr_en/wr_di exactly 1 cycle after the accepting edge.
REQ-020 States are IDLE, DATA and DROP.
REQ-021 IDLE with an accepted SOF beat:
- Write the word with sof=1 and set len=1.
- If eof is also set, write sof=1,eof=1, pulse done, and stay in IDLE.
- Otherwise go to DATA.
REQ-022 IDLE with an accepted beat without SOF:
- No write; pulse rx_err_nosof.
- Go to DROP unless the beat carries eof, in which case stay in IDLE.
REQ-023 DATA with an accepted beat: write it and increment len.
- On eof, write eof=1, pulse done with abort=0, and go to IDLE.
REQ-024 DATA with an accepted beat carrying SOF:
- Write it with eof=1, abort=1, pulse done with abort=1.
- Go to DROP, or to IDLE if the beat also carries eof.
REQ-025 DATA when len reaches C_MAX_WORDS without eof:
- That word is written with eof=1, abort=1, and done pulses with abort=1.
- Go to DROP.
REQ-026 DATA with trn_rsrc_dsc_n=0, independent of rdy:
- Write data=0, eof=1, abort=1; len is unchanged.
- Pulse done with abort=1 and go to IDLE.
- Any beat accepted in the same cycle is discarded.
REQ-027 DROP: accepted beats are discarded.
- eof or dsc returns to IDLE; no error pulse is raised.
REQ-028 dsc in IDLE or DROP: DROP goes to IDLE; IDLE ignores it.
REQ-029 If a write is due while wr_full=1:
- Suppress wr_en and pulse rx_err_ovf.
- The state machine proceeds as if the write occurred.
REQ-030 len is 10 bits and saturates at C_MAX_WORDS; it never wraps.
REQ-031 rx_frame_len updates in the same cycle as the rx_frame_done pulse.

Reset
REQ-032 While phyreset_n=0 at a clock edge:
- state=IDLE, trn_rdst_rdy_n=1, wr_en=0, wr_di=0, len=0.
- rx_frame_done, rx_frame_abort, rx_frame_len, rx_err_nosof and rx_err_ovf are all 0.
REQ-033 Reset mid-frame drops the partial frame without writing an eof word.
- Downstream recovers on the next sof.

Structure
REQ-034 The shared package holds:
- Bit positions of the 36-bit FIFO word (SOF=35, EOF=34, ABORT=33).
- The state encodings.
- The default C_MAX_WORDS.
REQ-035 The block is a single module with no sub-modules; the txll_ll FIFO-word format is reused unchanged.

Verification
REQ-036 4-word frame 0x11..0x44 with the FIFO empty:
- 4 writes, wr_di[35:34] = 10,00,00,01.
- done pulses with len=4, abort=0.
REQ-037 Single beat with sof and eof, data 0xA5A5A5A5:
- One write, wr_di = 0xC_A5A5A5A5.
- done with len=1.
REQ-038 Frame of 3 words, then dsc asserted:
- A 4th write of 0x6_00000000.
- done with len=3, abort=1.
- The following frame is received intact.
REQ-039 Beat without sof, then 2 beats, then eof:
- rx_err_nosof pulses once.
- No writes until the next sof.
REQ-040 C_MAX_WORDS=4 with a 6-word frame:
- 4 writes, the last flagged eof=1, abort=1; done with len=4, abort=1.
- The remaining 2 words are dropped.
REQ-041 Raise almost_full mid-frame:
- trn_rdst_rdy_n=1 on the next cycle; no beats are lost.
- Forcing wr_full while a write is due pulses rx_err_ovf.

Source files
------------

// File: rtl/rxll_ll_pkg.sv
// ============================================================================
// rxll_ll_pkg : shared FIFO-word layout, FSM encodings and defaults
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rxll_ll_pkg;

  localparam int DEFAULT_MAX_WORDS = 512;

  localparam int SOF_BIT   = 35;
  localparam int EOF_BIT   = 34;
  localparam int ABORT_BIT = 33;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef logic [35:0] fifo_word_t;

  function automatic fifo_word_t mk_word(input logic sof, input logic eof,
                                         input logic abort, input logic [31:0] data);
    fifo_word_t w;
    w            = '0;
    w[SOF_BIT]   = sof;
    w[EOF_BIT]   = eof;
    w[ABORT_BIT] = abort;
    w[31:0]      = data;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rxll_ll_if.sv
// ============================================================================
// rxll_ll_if : LocalLink receive bundle (source = master, sink = slave)
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface rxll_ll_if;

  logic [31:0] trn_rd;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic        trn_rdst_rdy_n;

  modport master (
    output trn_rd, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n,
    input  trn_rdst_rdy_n
  );

  modport slave (
    input  trn_rd, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n,
    output trn_rdst_rdy_n
  );

endinterface

`default_nettype wire

// File: rtl/rxll_ll.sv
// ============================================================================
// rxll_ll  : LocalLink receive framer writing 36-bit tagged words to a FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module rxll_ll
  import rxll_ll_pkg::*;
#(
  parameter int C_MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  wire logic        phyclk,
  input  wire logic        phyreset_n,
  rxll_ll_if.slave         ll,
  output logic             wr_clk,
  output logic             wr_en,
  output logic [35:0]      wr_di,
  input  wire logic        wr_full,
  input  wire logic        wr_almost_full,
  output logic             rx_frame_done,
  output logic [9:0]       rx_frame_len,
  output logic             rx_frame_abort,
  output logic             rx_err_nosof,
  output logic             rx_err_ovf
);

  localparam logic [9:0] MAX_LEN = 10'(C_MAX_WORDS);

  logic [1:0]  state_q, state_d;
  logic [9:0]  len_q, len_d, len_inc;
  logic        rdy_n_q;
  logic        wr_en_q, ovf_q, done_q, abort_q, nosof_q;
  logic [9:0]  flen_q;
  fifo_word_t  wr_di_q, word_d;
  logic        wr_due, done_d, abort_d, nosof_d;
  logic        acc, sof, eof, dsc;

  assign acc     = ~ll.trn_rsrc_rdy_n & ~rdy_n_q;
  assign sof     = ~ll.trn_rsof_n;
  assign eof     = ~ll.trn_reof_n;
  assign dsc     = ~ll.trn_rsrc_dsc_n;
  assign len_inc = (len_q == MAX_LEN) ? len_q : len_q + 10'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wr_due  = 1'b0;
    word_d  = '0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    nosof_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (sof) begin
            wr_due = 1'b1;
            word_d = mk_word(1'b1, eof, 1'b0, ll.trn_rd);
            len_d  = 10'd1;
            if (eof) done_d  = 1'b1;
            else     state_d = ST_DATA;
          end else begin
            nosof_d = 1'b1;
            if (!eof) state_d = ST_DROP;
          end
        end
      end
      ST_DATA: begin
        // Discontinue wins over any beat accepted in the same cycle
        if (dsc) begin
          wr_due  = 1'b1;
          word_d  = mk_word(1'b0, 1'b1, 1'b1, 32'h0);
          done_d  = 1'b1;
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (acc) begin
          wr_due = 1'b1;
          len_d  = len_inc;
          if (sof) begin
            word_d  = mk_word(1'b0, 1'b1, 1'b1, ll.trn_rd);
            done_d  = 1'b1;
            abort_d = 1'b1;
            state_d = eof ? ST_IDLE : ST_DROP;
          end else if (eof) begin
            word_d  = mk_word(1'b0, 1'b1, 1'b0, ll.trn_rd);
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (len_inc == MAX_LEN) begin
            word_d  = mk_word(1'b0, 1'b1, 1'b1, ll.trn_rd);
            done_d  = 1'b1;
            abort_d = 1'b1;
            state_d = ST_DROP;
          end else begin
            word_d  = mk_word(1'b0, 1'b0, 1'b0, ll.trn_rd);
          end
        end
      end
      ST_DROP: begin
        if (dsc || (acc && eof)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge phyclk) begin
    if (!phyreset_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      rdy_n_q <= 1'b1;
      wr_en_q <= 1'b0;
      wr_di_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      nosof_q <= 1'b0;
      flen_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rdy_n_q <= wr_almost_full | wr_full;
      // A write blocked by a full FIFO is flagged but the FSM still advances
      wr_en_q <= wr_due & ~wr_full;
      ovf_q   <= wr_due & wr_full;
      if (wr_due) wr_di_q <= word_d;
      done_q  <= done_d;
      nosof_q <= nosof_d;
      if (done_d) begin
        flen_q  <= len_d;
        abort_q <= abort_d;
      end
    end
  end

  assign ll.trn_rdst_rdy_n = rdy_n_q;
  assign wr_clk            = phyclk;
  assign wr_en             = wr_en_q;
  assign wr_di             = wr_di_q;
  assign rx_frame_done     = done_q;
  assign rx_frame_len      = flen_q;
  assign rx_frame_abort    = abort_q;
  assign rx_err_nosof      = nosof_q;
  assign rx_err_ovf        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rxll_ll.sv
// ============================================================================
// tb_rxll_ll : directed bench for rxll_ll (instance built with 4-word frames)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_rxll_ll;

  logic        phyclk = 1'b0;
  logic        phyreset_n;
  logic        wr_clk, wr_en, wr_full, wr_almost_full;
  logic [35:0] wr_di;
  logic        rx_frame_done, rx_frame_abort, rx_err_nosof, rx_err_ovf;
  logic [9:0]  rx_frame_len;

  int total = 0;
  int bad   = 0;

  logic [35:0] wq[$];
  int          nosof_cnt, ovf_cnt, done_cnt;
  logic [9:0]  last_len;
  logic        last_abort;

  rxll_ll_if ll ();

  rxll_ll #(.C_MAX_WORDS(4)) dut (
    .phyclk         (phyclk),
    .phyreset_n     (phyreset_n),
    .ll             (ll.slave),
    .wr_clk         (wr_clk),
    .wr_en          (wr_en),
    .wr_di          (wr_di),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .rx_frame_done  (rx_frame_done),
    .rx_frame_len   (rx_frame_len),
    .rx_frame_abort (rx_frame_abort),
    .rx_err_nosof   (rx_err_nosof),
    .rx_err_ovf     (rx_err_ovf)
  );

  always #5 phyclk = ~phyclk;

  always @(negedge phyclk) begin
    if (wr_en === 1'b1) wq.push_back(wr_di);
    if (rx_err_nosof === 1'b1) nosof_cnt++;
    if (rx_err_ovf === 1'b1) ovf_cnt++;
    if (rx_frame_done === 1'b1) begin
      done_cnt++;
      last_len   = rx_frame_len;
      last_abort = rx_frame_abort;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge phyclk);
  endtask

  task automatic clr();
    wq.delete();
    nosof_cnt = 0;
    ovf_cnt   = 0;
    done_cnt  = 0;
  endtask

  // Offer one beat from a negedge and hold it until the sink takes it
  task automatic send(input logic s, input logic e, input logic [31:0] d);
    int   n;
    logic took;
    n    = 0;
    took = 1'b0;
    ll.trn_rsrc_rdy_n = 1'b0;
    ll.trn_rsof_n     = ~s;
    ll.trn_reof_n     = ~e;
    ll.trn_rd         = d;
    while (!took && n < 20) begin
      took = (ll.trn_rdst_rdy_n === 1'b0);
      @(posedge phyclk);
      @(negedge phyclk);
      n++;
    end
    ll.trn_rsrc_rdy_n = 1'b1;
    ll.trn_rsof_n     = 1'b1;
    ll.trn_reof_n     = 1'b1;
    check("beat_accepted", {63'd0, took}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ll.trn_rd         = '0;
    ll.trn_rsof_n     = 1'b1;
    ll.trn_reof_n     = 1'b1;
    ll.trn_rsrc_rdy_n = 1'b1;
    ll.trn_rsrc_dsc_n = 1'b1;
    wr_full           = 1'b0;
    wr_almost_full    = 1'b0;
    phyreset_n        = 1'b0;
    clr();
    idle(3);

    check("rst_dst_rdy_n", {63'd0, ll.trn_rdst_rdy_n}, 64'd1);
    check("rst_wr_en",     {63'd0, wr_en}, 64'd0);
    check("rst_wr_di",     {28'd0, wr_di}, 64'd0);
    check("rst_done",      {63'd0, rx_frame_done}, 64'd0);
    check("rst_len",       {54'd0, rx_frame_len}, 64'd0);
    check("rst_abort",     {63'd0, rx_frame_abort}, 64'd0);
    check("rst_nosof",     {63'd0, rx_err_nosof}, 64'd0);
    check("rst_ovf",       {63'd0, rx_err_ovf}, 64'd0);
    check("wr_clk_follow", {63'd0, wr_clk}, {63'd0, phyclk});

    phyreset_n = 1'b1;
    idle(2);
    check("dst_rdy_after_rst", {63'd0, ll.trn_rdst_rdy_n}, 64'd0);

    // 4-word frame, FIFO empty
    clr();
    send(1, 0, 32'h11);
    send(0, 0, 32'h22);
    send(0, 0, 32'h33);
    send(0, 1, 32'h44);
    idle(2);
    check("f4_count", wq.size(), 4);
    check("f4_w0", {28'd0, wq[0]}, 64'h8_0000_0011);
    check("f4_w1", {28'd0, wq[1]}, 64'h0_0000_0022);
    check("f4_w2", {28'd0, wq[2]}, 64'h0_0000_0033);
    check("f4_w3", {28'd0, wq[3]}, 64'h4_0000_0044);
    check("f4_done", done_cnt, 1);
    check("f4_len", {54'd0, last_len}, 64'd4);
    check("f4_abort", {63'd0, last_abort}, 64'd0);

    // single-beat frame, checked one cycle after the accepting edge
    clr();
    send(1, 1, 32'hA5A5A5A5);
    check("one_wr_en", {63'd0, wr_en}, 64'd1);
    check("one_wr_di", {28'd0, wr_di}, 64'hC_A5A5_A5A5);
    check("one_done", {63'd0, rx_frame_done}, 64'd1);
    check("one_len", {54'd0, rx_frame_len}, 64'd1);
    idle(1);
    check("one_wr_en_drop", {63'd0, wr_en}, 64'd0);
    check("one_done_pulse", {63'd0, rx_frame_done}, 64'd0);
    idle(1);
    check("one_count", wq.size(), 1);

    // 3 words then discontinue, then an intact frame
    clr();
    send(1, 0, 32'h01);
    send(0, 0, 32'h02);
    send(0, 0, 32'h03);
    ll.trn_rsrc_dsc_n = 1'b0;
    idle(1);
    ll.trn_rsrc_dsc_n = 1'b1;
    check("dsc_wr_en", {63'd0, wr_en}, 64'd1);
    check("dsc_wr_di", {28'd0, wr_di}, 64'h6_0000_0000);
    check("dsc_done", {63'd0, rx_frame_done}, 64'd1);
    check("dsc_len", {54'd0, rx_frame_len}, 64'd3);
    check("dsc_abort", {63'd0, rx_frame_abort}, 64'd1);
    send(1, 0, 32'hAA);
    send(0, 1, 32'hBB);
    idle(2);
    check("dsc_count", wq.size(), 6);
    check("dsc_next_w0", {28'd0, wq[4]}, 64'h8_0000_00AA);
    check("dsc_next_w1", {28'd0, wq[5]}, 64'h4_0000_00BB);
    check("dsc_next_len", {54'd0, last_len}, 64'd2);
    check("dsc_next_abort", {63'd0, last_abort}, 64'd0);

    // missing sof: one error, everything dropped up to eof
    clr();
    send(0, 0, 32'h1);
    send(0, 0, 32'h2);
    send(0, 0, 32'h3);
    send(0, 1, 32'h4);
    idle(2);
    check("nosof_pulses", nosof_cnt, 1);
    check("nosof_writes", wq.size(), 0);
    check("nosof_done", done_cnt, 0);
    send(1, 1, 32'h55);
    idle(2);
    check("nosof_recover", {28'd0, wq[0]}, 64'hC_0000_0055);

    // oversize frame: 6 words into a 4-word limit
    clr();
    send(1, 0, 32'h1);
    send(0, 0, 32'h2);
    send(0, 0, 32'h3);
    send(0, 0, 32'h4);
    send(0, 0, 32'h5);
    send(0, 1, 32'h6);
    idle(2);
    check("max_count", wq.size(), 4);
    check("max_w2", {28'd0, wq[2]}, 64'h0_0000_0003);
    check("max_w3", {28'd0, wq[3]}, 64'h6_0000_0004);
    check("max_done", done_cnt, 1);
    check("max_len", {54'd0, last_len}, 64'd4);
    check("max_abort", {63'd0, last_abort}, 64'd1);
    check("max_nosof", nosof_cnt, 0);

    // almost_full back-pressure mid-frame
    clr();
    send(1, 0, 32'h71);
    wr_almost_full = 1'b1;
    send(0, 0, 32'h72);
    check("af_dst_rdy_n", {63'd0, ll.trn_rdst_rdy_n}, 64'd1);
    ll.trn_rsrc_rdy_n = 1'b0;
    ll.trn_rd         = 32'h73;
    idle(3);
    check("af_stalled", wq.size(), 2);
    wr_almost_full = 1'b0;
    send(0, 0, 32'h73);
    send(0, 1, 32'h74);
    idle(2);
    check("af_count", wq.size(), 4);
    check("af_w2", {28'd0, wq[2]}, 64'h0_0000_0073);
    check("af_w3", {28'd0, wq[3]}, 64'h4_0000_0074);
    check("af_len", {54'd0, last_len}, 64'd4);

    // full while a write is due
    clr();
    send(1, 0, 32'h81);
    wr_full = 1'b1;
    send(0, 1, 32'h82);
    check("ovf_wr_en", {63'd0, wr_en}, 64'd0);
    check("ovf_pulse", {63'd0, rx_err_ovf}, 64'd1);
    check("ovf_done", {63'd0, rx_frame_done}, 64'd1);
    check("ovf_len", {54'd0, rx_frame_len}, 64'd2);
    wr_full = 1'b0;
    idle(2);
    check("ovf_count", wq.size(), 1);
    check("ovf_pulses", ovf_cnt, 1);

    // reset mid-frame drops the partial frame with no eof word
    clr();
    send(1, 0, 32'h91);
    idle(1);
    phyreset_n = 1'b0;
    idle(1);
    phyreset_n = 1'b1;
    send(1, 1, 32'h92);
    idle(2);
    check("rstmid_count", wq.size(), 2);
    check("rstmid_w0", {28'd0, wq[0]}, 64'h8_0000_0091);
    check("rstmid_w1", {28'd0, wq[1]}, 64'hC_0000_0092);
    check("rstmid_done", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
